// File: rtl/operand_fetch_stage_if.sv
// Decode-side handshake between IF/ID and the operand fetch stage:
// instruction fields flow down, stall flows back up.
interface operand_fetch_stage_if #(
   parameter int DW = 32,
   parameter int AW = 4
);
   logic          in_valid;
   logic [AW-1:0] in_rn;
   logic [AW-1:0] in_rm;
   logic          in_use_a;
   logic          in_use_b;
   logic [AW-1:0] in_rd;
   logic          in_wr;
   logic [DW-1:0] in_pc;
   logic          stall;

   modport master (
      output in_valid, in_rn, in_rm, in_use_a, in_use_b, in_rd, in_wr, in_pc,
      input  stall
   );

   modport slave (
      input  in_valid, in_rn, in_rm, in_use_a, in_use_b, in_rd, in_wr, in_pc,
      output stall
   );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register-file read, EX/MEM/WB forwarding, load-use bubble
// insertion and the ID/EX output register.
module operand_fetch_stage #(
   parameter int DW = 32,
   parameter int AW = 4,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   operand_fetch_stage_if.slave dec,
   output logic [AW-1:0] rf_a_addr,
   output logic [AW-1:0] rf_b_addr,
   input  logic [DW-1:0] rf_a_data,
   input  logic [DW-1:0] rf_b_data,
   input  logic          ex_wr,
   input  logic [AW-1:0] ex_rd,
   input  logic [DW-1:0] ex_data,
   input  logic          ex_is_load,
   input  logic          mem_wr,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   input  logic          wb_wr,
   input  logic [AW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   input  logic          hold,
   input  logic          flush,
   output logic          stall,
   output logic          out_valid,
   output logic [DW-1:0] out_a,
   output logic [DW-1:0] out_b,
   output logic [AW-1:0] out_rd,
   output logic          out_wr,
   output logic [CW-1:0] bubble_cnt
);

   localparam logic [AW-1:0] PC_REG  = '1;
   localparam logic [DW-1:0] PC_OFS  = DW'(8);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic          hz;
   logic [DW-1:0] opnd_a;
   logic [DW-1:0] opnd_b;

   assign rf_a_addr = dec.in_rn;
   assign rf_b_addr = dec.in_rm;

   // Unused sources take raw RF data so the captured value stays deterministic.
   function automatic logic [DW-1:0] resolve(
      input logic [AW-1:0] r,
      input logic          used,
      input logic [DW-1:0] rf_data,
      input logic [DW-1:0] pc
   );
      logic [DW-1:0] v;
      v = rf_data;
      if (used) begin
         if (r == PC_REG)                           v = pc + PC_OFS;
         else if (ex_wr && ex_rd == r && !ex_is_load) v = ex_data;
         else if (mem_wr && mem_rd == r)            v = mem_data;
         else if (wb_wr && wb_rd == r)              v = wb_data;
      end
      return v;
   endfunction

   always_comb begin
      opnd_a = resolve(dec.in_rn, dec.in_use_a, rf_a_data, dec.in_pc);
      opnd_b = resolve(dec.in_rm, dec.in_use_b, rf_b_data, dec.in_pc);
   end

   assign hz = dec.in_valid && ex_wr && ex_is_load && (ex_rd != PC_REG) &&
               ((dec.in_use_a && ex_rd == dec.in_rn) ||
                (dec.in_use_b && ex_rd == dec.in_rm));

   assign stall     = (hz || hold) && !flush;
   assign dec.stall = stall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_wr     <= 1'b0;
         out_a      <= '0;
         out_b      <= '0;
         out_rd     <= '0;
         bubble_cnt <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_wr    <= 1'b0;
      end else if (hold) begin
         out_valid <= out_valid;
      end else if (hz) begin
         out_valid <= 1'b0;
         out_wr    <= 1'b0;
         if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CW'(1);
      end else begin
         out_valid <= dec.in_valid;
         out_wr    <= dec.in_valid && dec.in_wr;
         out_rd    <= dec.in_rd;
         out_a     <= opnd_a;
         out_b     <= opnd_b;
      end
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: driver pushes expected ID/EX contents,
// a monitor pops and compares one cycle later.
module tb_operand_fetch_stage;

   logic        clk;
   logic        reset_n;
   logic [31:0] rf [16];
   logic [3:0]  rf_a_addr, rf_b_addr;
   logic [31:0] rf_a_data, rf_b_data;
   logic        ex_wr, ex_is_load, mem_wr, wb_wr, hold, flush;
   logic [3:0]  ex_rd, mem_rd, wb_rd;
   logic [31:0] ex_data, mem_data, wb_data;
   logic        stall, out_valid, out_wr;
   logic [31:0] out_a, out_b;
   logic [3:0]  out_rd;
   logic [15:0] bubble_cnt;

   logic [3:0]  rf2_a_addr, rf2_b_addr;
   logic        stall2, out2_valid, out2_wr;
   logic [31:0] out2_a, out2_b;
   logic [3:0]  out2_rd;
   logic [1:0]  bubble_cnt2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          id;
      logic        ca;
      logic        cb;
      logic        v;
      logic        wr;
      logic [3:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] bub;
   } exp_t;

   exp_t exp_q[$];

   operand_fetch_stage_if #(.DW(32), .AW(4)) dec_if ();
   operand_fetch_stage_if #(.DW(32), .AW(4)) dec2_if ();

   assign dec2_if.in_valid = dec_if.in_valid;
   assign dec2_if.in_rn    = dec_if.in_rn;
   assign dec2_if.in_rm    = dec_if.in_rm;
   assign dec2_if.in_use_a = dec_if.in_use_a;
   assign dec2_if.in_use_b = dec_if.in_use_b;
   assign dec2_if.in_rd    = dec_if.in_rd;
   assign dec2_if.in_wr    = dec_if.in_wr;
   assign dec2_if.in_pc    = dec_if.in_pc;

   assign rf_a_data = rf[rf_a_addr];
   assign rf_b_data = rf[rf_b_addr];

   operand_fetch_stage #(.DW(32), .AW(4), .CW(16)) dut (
      .clk(clk), .reset_n(reset_n), .dec(dec_if),
      .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
      .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
      .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
      .hold(hold), .flush(flush), .stall(stall),
      .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
      .out_rd(out_rd), .out_wr(out_wr), .bubble_cnt(bubble_cnt)
   );

   operand_fetch_stage #(.DW(32), .AW(4), .CW(2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .dec(dec2_if),
      .rf_a_addr(rf2_a_addr), .rf_b_addr(rf2_b_addr),
      .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
      .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
      .hold(hold), .flush(flush), .stall(stall2),
      .out_valid(out2_valid), .out_a(out2_a), .out_b(out2_b),
      .out_rd(out2_rd), .out_wr(out2_wr), .bubble_cnt(bubble_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, req);
      end
   endtask

   // Monitor: compares one expectation per clock, one step after it was issued.
   initial begin
      exp_t e;
      logic [31:0] sat;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sat = (e.bub > 16'd3) ? 32'd3 : 32'(e.bub);
            check("out_valid", e.id, 32'(out_valid), 32'(e.v));
            check("out_wr", e.id, 32'(out_wr), 32'(e.wr));
            check("out_rd", e.id, 32'(out_rd), 32'(e.rd));
            if (e.ca) check("out_a", e.id, out_a, e.a);
            if (e.cb) check("out_b", e.id, out_b, e.b);
            check("bubble_cnt", e.id, 32'(bubble_cnt), 32'(e.bub));
            check("bubble_cnt_sat", e.id, 32'(bubble_cnt2), sat);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   int step_id = 0;

   task automatic step(input logic ca, input logic cb, input logic v, input logic wr,
                       input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] bub);
      exp_t e;
      step_id++;
      e.id = step_id; e.ca = ca; e.cb = cb; e.v = v; e.wr = wr;
      e.rd = rd; e.a = a; e.b = b; e.bub = bub;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_stall(input logic req);
      #1;
      check("stall", step_id + 1, 32'(stall), 32'(req));
   endtask

   task automatic clear_fwd();
      ex_wr = 0; ex_rd = 0; ex_data = 0; ex_is_load = 0;
      mem_wr = 0; mem_rd = 0; mem_data = 0;
      wb_wr = 0; wb_rd = 0; wb_data = 0;
   endtask

   task automatic set_instr(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                            input logic ua, input logic ub, input logic [3:0] rd,
                            input logic wr, input logic [31:0] pc);
      dec_if.in_valid = v; dec_if.in_rn = rn; dec_if.in_rm = rm;
      dec_if.in_use_a = ua; dec_if.in_use_b = ub; dec_if.in_rd = rd;
      dec_if.in_wr = wr; dec_if.in_pc = pc;
   endtask

   task automatic check_reset_state(input string nm);
      #1;
      check({nm, "_valid"}, 0, 32'(out_valid), 32'd0);
      check({nm, "_wr"}, 0, 32'(out_wr), 32'd0);
      check({nm, "_a"}, 0, out_a, 32'd0);
      check({nm, "_b"}, 0, out_b, 32'd0);
      check({nm, "_rd"}, 0, 32'(out_rd), 32'd0);
      check({nm, "_bub"}, 0, 32'(bubble_cnt), 32'd0);
      check({nm, "_bub_sat"}, 0, 32'(bubble_cnt2), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 | 32'(i);
      rf[1] = 32'hF0F0_F0F0;
      rf[3] = 32'hC3C3_C3C3;
      reset_n = 1'b0;
      hold = 0; flush = 0;
      clear_fwd();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check_reset_state("reset_init");
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;

      // Reset mid-stream
      set_instr(1, 1, 2, 1, 1, 7, 1, 0);
      chk_stall(0);
      step(1, 1, 1, 1, 7, 32'hF0F0_F0F0, 32'hA000_0002, 0);
      reset_n = 1'b0;
      check_reset_state("reset_mid");
      @(negedge clk);
      reset_n = 1'b1;
      step(1, 1, 1, 1, 7, 32'hF0F0_F0F0, 32'hA000_0002, 0);

      // Forward priority EX > MEM > WB > RF
      set_instr(1, 3, 3, 1, 1, 8, 1, 0);
      ex_wr = 1;  ex_rd = 3;  ex_data = 32'h11;
      mem_wr = 1; mem_rd = 3; mem_data = 32'h22;
      wb_wr = 1;  wb_rd = 3;  wb_data = 32'h33;
      step(1, 1, 1, 1, 8, 32'h11, 32'h11, 0);
      ex_wr = 0;
      step(1, 1, 1, 1, 8, 32'h22, 32'h22, 0);
      mem_wr = 0;
      step(1, 1, 1, 1, 8, 32'h33, 32'h33, 0);
      wb_wr = 0;
      step(1, 1, 1, 1, 8, 32'hC3C3_C3C3, 32'hC3C3_C3C3, 0);
      set_instr(1, 3, 4, 1, 1, 8, 1, 0);
      ex_wr = 1;  ex_rd = 4;  ex_data = 32'h11;
      mem_wr = 1; mem_rd = 3; mem_data = 32'h22;
      wb_wr = 1;  wb_rd = 4;  wb_data = 32'h33;
      step(1, 1, 1, 1, 8, 32'h22, 32'h11, 0);
      clear_fwd();

      // R15 reads the PC, never forwarded, never a hazard
      set_instr(1, 15, 2, 1, 1, 8, 1, 32'h100);
      ex_wr = 1; ex_rd = 15; ex_data = 32'hDEAD;
      step(1, 1, 1, 1, 8, 32'h108, 32'hA000_0002, 0);
      dec_if.in_pc = 32'hFFFF_FFFC;
      step(1, 1, 1, 1, 8, 32'h4, 32'hA000_0002, 0);
      ex_is_load = 1;
      chk_stall(0);
      step(1, 1, 1, 1, 8, 32'h4, 32'hA000_0002, 0);
      clear_fwd();

      // Load-use hazard: one bubble, then MEM forward
      set_instr(1, 1, 5, 1, 1, 6, 1, 0);
      ex_wr = 1; ex_is_load = 1; ex_rd = 5; ex_data = 32'h99;
      chk_stall(1);
      step(1, 1, 0, 0, 8, 32'h4, 32'hA000_0002, 1);
      ex_wr = 0; ex_is_load = 0;
      mem_wr = 1; mem_rd = 5; mem_data = 32'hAB;
      chk_stall(0);
      step(1, 1, 1, 1, 6, 32'hF0F0_F0F0, 32'hAB, 1);
      clear_fwd();
      set_instr(1, 1, 5, 1, 0, 6, 1, 0);
      ex_wr = 1; ex_is_load = 1; ex_rd = 5; ex_data = 32'h99;
      chk_stall(0);
      step(1, 0, 1, 1, 6, 32'hF0F0_F0F0, 32'h0, 1);
      set_instr(0, 1, 5, 1, 1, 6, 1, 0);
      chk_stall(0);
      step(1, 1, 0, 0, 6, 32'hF0F0_F0F0, 32'hA000_0005, 1);
      clear_fwd();

      // Hold freezes everything, even with a hazard present
      set_instr(1, 1, 2, 1, 1, 9, 1, 0);
      step(1, 1, 1, 1, 9, 32'hF0F0_F0F0, 32'hA000_0002, 1);
      hold = 1;
      set_instr(1, 3, 3, 1, 1, 10, 1, 0);
      chk_stall(1);
      step(1, 1, 1, 1, 9, 32'hF0F0_F0F0, 32'hA000_0002, 1);
      ex_wr = 1; ex_is_load = 1; ex_rd = 3;
      chk_stall(1);
      step(1, 1, 1, 1, 9, 32'hF0F0_F0F0, 32'hA000_0002, 1);
      set_instr(0, 4, 1, 1, 1, 11, 0, 32'h40);
      step(1, 1, 1, 1, 9, 32'hF0F0_F0F0, 32'hA000_0002, 1);
      hold = 0; flush = 1;
      set_instr(1, 3, 2, 1, 1, 12, 1, 0);
      chk_stall(0);
      step(1, 1, 0, 0, 9, 32'hF0F0_F0F0, 32'hA000_0002, 1);
      flush = 0;
      clear_fwd();

      // Saturation: five back-to-back load-use bubbles
      reset_n = 1'b0;
      check_reset_state("reset_sat");
      @(negedge clk);
      reset_n = 1'b1;
      set_instr(1, 0, 5, 0, 1, 11, 1, 0);
      ex_wr = 1; ex_is_load = 1; ex_rd = 5;
      for (int k = 1; k <= 5; k++) begin
         chk_stall(1);
         step(1, 1, 0, 0, 0, 32'h0, 32'h0, 16'(k));
      end
      clear_fwd();
      set_instr(1, 2, 1, 1, 1, 12, 1, 0);
      step(1, 1, 1, 1, 12, 32'hA000_0002, 32'hF0F0_F0F0, 5);

      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-side operand stage directly upstream of the execute datapath and downstream of the 16x32 register file.
- Drives the register file's two read-address ports and takes its two combinational read-data outputs.
- Forwards results from EX, MEM and WB, detects load-use hazards and inserts bubbles.
- Registers the resolved operands into the ID/EX pipeline register.

Parameters:
- DW, 32, datapath width
- AW, 4, register address width (16 registers, R15 = PC)
- CW, 16, width of the bubble-cycle counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_rn  in  AW  source register A
- in_rm  in  AW  source register B
- in_use_a  in  1  instruction reads rn
- in_use_b  in  1  instruction reads rm
- in_rd  in  AW  destination register
- in_wr  in  1  instruction writes rd
- in_pc  in  DW  address of the instruction
- rf_a_addr  out  AW  register file port A address (= in_rn, combinational)
- rf_b_addr  out  AW  register file port B address (= in_rm, combinational)
- rf_a_data  in  DW  register file port A data
- rf_b_data  in  DW  register file port B data
- ex_wr, ex_rd, ex_data, ex_is_load  in  1/AW/DW/1  EX-stage result
- mem_wr, mem_rd, mem_data  in  1/AW/DW  MEM-stage result
- wb_wr, wb_rd, wb_data  in  1/AW/DW  value being written into the register file this cycle
- hold  in  1  downstream stall; freeze the output register
- flush  in  1  branch taken; kill the instruction being captured
- stall  out  1  hold IF/ID (combinational)
- out_valid, out_a, out_b, out_rd, out_wr  out  1/DW/DW/AW/1  ID/EX register
- bubble_cnt  out  CW  saturating count of inserted bubbles

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0, out_wr=0, out_a=0, out_b=0, out_rd=0, bubble_cnt=0.
  - Takes effect immediately, mid-operation included; the first capture happens on the first rising edge after release.
- Operand resolution for source s (A or B) with register r, combinational, first match wins:
  - r==15 → in_pc+8, mod 2^DW. R15 is never forwarded.
  - ex_wr && ex_rd==r && !ex_is_load → ex_data.
  - mem_wr && mem_rd==r → mem_data.
  - wb_wr && wb_rd==r → wb_data. This covers the write-before-read gap, since the register file updates on the same edge.
  - otherwise → rf data.
- Load-use hazard:
  - hz = in_valid && ex_wr && ex_is_load && ex_rd!=15 && ((in_use_a && ex_rd==in_rn) || (in_use_b && ex_rd==in_rm)).
  - Unused sources never cause a hazard or select a forward; their operand value is don't-care but must be deterministic.
- stall = (hz || hold) && !flush.
- Rising-edge update, first matching case wins:
  1. flush: out_valid←0, out_wr←0, other fields unchanged. No bubble count.
  2. hold: all outputs hold.
  3. hz: bubble. out_valid←0, out_wr←0; bubble_cnt←bubble_cnt+1, saturating at 2^CW−1.
  4. else: out_valid←in_valid, out_wr←in_valid&&in_wr, out_rd←in_rd, out_a/out_b←resolved operands.
- Latency: one cycle from in_* to out_*. A load-use stall costs exactly one bubble: the next cycle the load has moved to MEM and is forwarded from mem_data.
- hold and hz together: hold wins and no bubble is counted. hz is re-evaluated on the following cycle.
- in_valid=0: captured as a bubble (out_valid=0). It is not counted, and hz is forced to 0.

Test Plan:
1. Reset: reset_n=0 mid-stream with out_valid=1 → all outputs 0 immediately. After release, in_valid=1, rn=1 with RF R1=0xF0F0F0F0 → next edge out_a=0xF0F0F0F0.
2. Forward priority: rn=rm=3, ex_data=0x11, mem_data=0x22, wb_data=0x33, all writing R3 → out_a=out_b=0x11. Drop ex_wr → 0x22. Drop mem_wr → 0x33. Drop wb_wr → RF value.
3. PC read: rn=15, in_pc=0x100, ex_wr with ex_rd=15 → out_a=0x108. With in_pc=0xFFFFFFFC → out_a=0x4.
4. Load-use: ex_is_load=1, ex_rd=5, rm=5, use_b=1 → stall=1, out_valid=0, bubble_cnt=1. Next cycle mem_rd=5, mem_data=0xAB → out_b=0xAB, stall=0. Same stimulus with use_b=0 → no stall.
5. hold=1 for 3 cycles with changing inputs → outputs frozen, bubble_cnt unchanged. flush asserted together with hz → stall=0, out_valid=0, bubble_cnt unchanged.
6. Saturation: CW=2, five consecutive load-use hazards → bubble_cnt sequence 1,2,3,3,3.
